obi_mem_responder: RTL and testbench

- Memory-side responder for the core's instruction or data request/grant/rvalid bus (req/gnt/rvalid, we/be/addr/wdata/rdata/err).
- Backs the bus with a word-organised internal array, grants requests subject to an outstanding-transaction limit, and returns in-order responses a fixed number of cycles after grant.
- One instance serves the fetch port (we_i tied 0); a second serves the LSU port. Used in simulation benches in place of burst memory.

---
 rtl/obi_mem_responder.sv | 151 +++++++++++++++
 tb/tb_obi_mem_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// -----------------------------------------------------------------------------
// obi_mem_responder
//
// Memory-side responder for a req/gnt/rvalid bus. The bus is backed by a
// word-organised array. Requests are granted while the number of
// granted-but-unanswered transfers stays below MAX_OUTSTANDING. Responses
// return in grant order, exactly LATENCY cycles after the grant edge.
//
// Optional build macro:
//   OBI_RESP_STALL_EN - an 8-bit Fibonacci LFSR (taps 8,6,5,4) is seeded with
//                       LFSR_SEED and denies the grant whenever lfsr[1:0]==0.
//                       When the macro is not defined, the responder never
//                       stalls and contains no LFSR.
//
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   req_i          request valid from the initiator
//   we_i           1 = write, 0 = read
//   be_i[3:0]      byte enables (writes only)
//   addr_i[31:0]   byte address; bits [1:0] are ignored
//   wdata_i[31:0]  write data
//   gnt_o          request accepted this cycle (combinational)
//   rvalid_o       response valid, one cycle per granted request
//   rdata_o[31:0]  read data; 0 for writes and for errors
//   err_o          address out of range (qualified by rvalid_o)
//   outstanding_o  current count of granted-but-unanswered transfers
// -----------------------------------------------------------------------------
module obi_mem_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   req_i,
  input  logic                                   we_i,
  input  logic [3:0]                             be_i,
  input  logic [31:0]                            addr_i,
  input  logic [31:0]                            wdata_i,
  output logic                                   gnt_o,
  output logic                                   rvalid_o,
  output logic [31:0]                            rdata_o,
  output logic                                   err_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned       CNT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned       IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0]       MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);

  logic [31:0]      mem [MEM_WORDS];
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] widx;
  logic             stall;
  logic             xfer;
  logic [CNT_W-1:0] out_q;
  logic             unused_bits;

  // Response pipeline: index 0 is loaded at the grant edge, index
  // LATENCY-1 drives the response outputs.
  logic             vld_p   [LATENCY];
  logic [31:0]      rdata_p [LATENCY];
  logic             err_p   [LATENCY];

  // Unsigned wrap-around makes addresses below BASE_ADDR fall out of range too.
  assign offset   = addr_i - BASE_ADDR;
  assign in_range = (offset < MEM_BYTES);
  assign widx     = offset[IDX_W+1:2];

  // The rvalid of this cycle deliberately does not free a slot for a grant
  // in the same cycle.
  assign gnt_o = rst_ni && req_i && (out_q < MAX_CNT) && !stall;
  assign xfer  = req_i && gnt_o;

`ifdef OBI_RESP_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign stall       = (lfsr_q[1:0] == 2'b00);
  assign unused_bits = ^offset[1:0];
`else
  assign stall       = 1'b0;
  assign unused_bits = ^{offset[1:0], LFSR_SEED};
`endif

  // Outstanding counter: a grant and a response in the same cycle cancel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= '0;
    end else if (xfer && !rvalid_o) begin
      out_q <= out_q + CNT_W'(1);
    end else if (!xfer && rvalid_o) begin
      out_q <= out_q - CNT_W'(1);
    end
  end

  // Array write at the grant edge. Out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (xfer && we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem[widx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // ---- stage 0: capture at the grant edge, then shift toward the output ----
  // Valid bits are reset so that in-flight responses are discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0] <= xfer;
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Payload is not reset. It is only observed through the valid bit.
  always_ff @(posedge clk_i) begin
    rdata_p[0] <= (we_i || !in_range) ? 32'h0 : mem[widx];
    err_p[0]   <= !in_range;
    for (int i = 1; i < LATENCY; i++) begin
      rdata_p[i] <= rdata_p[i-1];
      err_p[i]   <= err_p[i-1];
    end
  end

  // ---- output stage: last pipeline entry, gated by its valid bit ----
  assign rvalid_o      = vld_p[LATENCY-1];
  assign rdata_o       = rvalid_o ? rdata_p[LATENCY-1] : 32'h0;
  assign err_o         = rvalid_o && err_p[LATENCY-1];
  assign outstanding_o = out_q;

endmodule

// File: tb/tb_obi_mem_responder.sv
// -----------------------------------------------------------------------------
// Bench for obi_mem_responder (default build, stall disabled).
// u_dut  : LATENCY=2, MAX_OUTSTANDING=2, checked every cycle against a
//          queue-based transaction model plus literal expectations.
// u_dut2 : LATENCY=3, MAX_OUTSTANDING=1, checked against a hand-computed
//          per-cycle gnt/outstanding/rvalid table.
// -----------------------------------------------------------------------------
module tb_obi_mem_responder;

  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [1:0]  outstanding;

  logic        req2, we2;
  logic [3:0]  be2;
  logic [31:0] addr2, wdata2;
  logic        gnt2, rvalid2, err2;
  logic [31:0] rdata2;
  logic [0:0]  outstanding2;

  always #5 clk = ~clk;

  obi_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(LAT),
    .MAX_OUTSTANDING(MAXO), .LFSR_SEED(8'hA5)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .outstanding_o(outstanding)
  );

  obi_mem_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3),
    .MAX_OUTSTANDING(1), .LFSR_SEED(8'hA5)
  ) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req2), .we_i(we2), .be_i(be2),
    .addr_i(addr2), .wdata_i(wdata2), .gnt_o(gnt2), .rvalid_o(rvalid2),
    .rdata_o(rdata2), .err_o(err2), .outstanding_o(outstanding2)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    logic        err;
    bit          known;
  } pend_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int unsigned cyc;
  } resp_t;

  pend_t       pq[$];
  resp_t       log_q[$];
  logic [31:0] mmem [int unsigned];

  int unsigned cyc = 0;
  int unsigned g_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          max_out = 0;

  // model scratch
  logic        m_gnt, m_rv;
  logic [31:0] m_off, m_cur;
  int unsigned m_w;
  pend_t       m_p;
  resp_t       m_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of u_dut: pending responses are a FIFO stamped
  // with their due cycle; outstanding is simply the FIFO occupancy.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      chk("rst_outstanding", outstanding, 0);
      pq.delete();
    end else begin
      m_gnt = req && (pq.size() < MAXO);
      chk("gnt", gnt, m_gnt);
      chk("outstanding", outstanding, pq.size());
      if (int'(outstanding) > max_out) max_out = int'(outstanding);
      m_rv = (pq.size() > 0) && (pq[0].due == cyc);
      chk("rvalid", rvalid, m_rv);
      if (rvalid) begin
        m_r.data = rdata; m_r.err = err; m_r.cyc = cyc;
        log_q.push_back(m_r);
      end
      if (m_rv) begin
        m_p = pq.pop_front();
        if (m_p.known) chk("rdata", rdata, m_p.data);
        chk("err", err, m_p.err);
      end
      if (m_gnt) begin
        m_off   = addr - 32'h0;
        m_w     = m_off >> 2;
        m_p.due = cyc + LAT;
        m_p.err = !(m_off < 32'd4096);
        m_p.data = 32'h0;
        m_p.known = 1'b1;
        if (we) begin
          if (!m_p.err) begin
            m_cur = mmem.exists(m_w) ? mmem[m_w] : 32'h0;
            for (int i = 0; i < 4; i++) if (be[i]) m_cur[8*i +: 8] = wdata[8*i +: 8];
            mmem[m_w] = m_cur;
          end
        end else if (!m_p.err) begin
          if (mmem.exists(m_w)) m_p.data = mmem[m_w];
          else m_p.known = 1'b0;
        end
        pq.push_back(m_p);
      end
    end
  end

  // Present a request and hold it until granted; returns 1 ns after the grant edge.
  task automatic do_req(input logic w, input logic [3:0] b, input logic [31:0] a,
                        input logic [31:0] d);
    bit ok = 1'b0;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (gnt) begin
        ok = 1'b1;
        g_cyc = cyc;
      end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL grant_timeout: no gnt for addr %h within 20 cycles", a);
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  // Single transaction with literal expectations on its response.
  task automatic xact(input string name, input logic w, input logic [3:0] b,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_d, input logic exp_e);
    int idx;
    bit seen = 1'b0;
    drain();
    idx = log_q.size();
    do_req(w, b, a, d);
    for (int n = 0; n < 10 && !seen; n++) begin
      @(posedge clk); #1;
      if (log_q.size() > idx) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no rvalid within 10 cycles", name);
    end else begin
      chk({name, "_rdata"}, log_q[idx].data, exp_d);
      chk({name, "_err"}, log_q[idx].err, exp_e);
      chk({name, "_latency"}, log_q[idx].cyc - g_cyc, LAT);
    end
  endtask

  logic [8:0]  t_gnt2 = 9'b0_0001_0001;
  logic [8:0]  t_out2 = 9'b0_1110_1110;
  logic [8:0]  t_rv2  = 9'b0_1000_1000;
  logic [31:0] burst_exp;
  int          bidx, g2, rv2_cnt;

  initial begin
    rst_n = 1'b0;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0; wdata = 32'h0;
    req2 = 1'b0; we2 = 1'b0; be2 = 4'h0; addr2 = 32'h0; wdata2 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt_with_req", gnt, 0);
    chk("reset_outstanding_lit", outstanding, 0);
    chk("reset_rvalid_lit", rvalid, 0);
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    xact("wr_full", 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xact("rd_full", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    xact("wr_byte0", 1'b1, 4'b0001, 32'h10, 32'h0000_00AA, 32'h0, 1'b0);
    xact("rd_byte0", 1'b0, 4'h0, 32'h10, 32'h0, 32'hDEAD_BEAA, 1'b0);

    // back-to-back reads over words 0..5 (word 4 holds DEADBEAA)
    for (int i = 0; i < 6; i++) begin
      if (i != 4) do_req(1'b1, 4'hF, 32'(i * 4), 32'hC0DE_0000 + 32'(i));
    end
    drain();
    bidx = log_q.size();
    max_out = 0;
    for (int i = 0; i < 6; i++) do_req(1'b0, 4'hF, 32'(i * 4), 32'h0);
    drain();
    for (int i = 0; i < 6; i++) begin
      burst_exp = (i == 4) ? 32'hDEAD_BEAA : 32'hC0DE_0000 + 32'(i);
      if (bidx + i < log_q.size())
        chk($sformatf("burst_rd%0d", i), log_q[bidx + i].data, burst_exp);
      else
        chk($sformatf("burst_rd%0d_present", i), 32'(log_q.size()), 32'(bidx + 6));
    end
    chk("burst_max_outstanding", 32'(max_out), 32'd2);

    xact("rd_oor", 1'b0, 4'hF, 32'h0000_1000, 32'h0, 32'h0, 1'b1);
    xact("wr_oor", 1'b1, 4'hF, 32'h0000_1000, 32'h5555_5555, 32'h0, 1'b1);
    xact("rd_alias0", 1'b0, 4'hF, 32'h0, 32'h0, 32'hC0DE_0000, 1'b0);
    xact("wr_be0", 1'b1, 4'h0, 32'h4, 32'hFFFF_FFFF, 32'h0, 1'b0);
    xact("rd_be0", 1'b0, 4'hF, 32'h4, 32'h0, 32'hC0DE_0001, 1'b0);

    // reset one cycle after a grant: the in-flight read must vanish
    drain();
    bidx = log_q.size();
    do_req(1'b0, 4'hF, 32'h10, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_no_rvalid", 32'(log_q.size()), 32'(bidx));
    @(negedge clk);
    chk("rst_mid_outstanding", outstanding, 0);
    xact("rd_retained", 1'b0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEAA, 1'b0);

    // LATENCY=3, MAX_OUTSTANDING=1: write then read of word 0
    drain();
    req2 = 1'b1; we2 = 1'b1; be2 = 4'hF; addr2 = 32'h0; wdata2 = 32'h1234_5678;
    g2 = 0; rv2_cnt = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("lat3_gnt_c%0d", c), gnt2, t_gnt2[c]);
      chk($sformatf("lat3_out_c%0d", c), outstanding2, t_out2[c]);
      chk($sformatf("lat3_rvalid_c%0d", c), rvalid2, t_rv2[c]);
      if (rvalid2) begin
        chk($sformatf("lat3_rdata%0d", rv2_cnt), rdata2,
            (rv2_cnt == 0) ? 32'h0 : 32'h1234_5678);
        chk($sformatf("lat3_err%0d", rv2_cnt), err2, 0);
        rv2_cnt++;
      end
      if (gnt2) g2++;
      @(posedge clk); #1;
      if (g2 >= 1) we2 = 1'b0;
      if (g2 >= 2) req2 = 1'b0;
    end
    chk("lat3_rvalid_count", 32'(rv2_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
